// File: rtl/hex_arb_pkg.sv
// Shared types and constants for the HEX display write arbiter.
package hex_arb_pkg;

   typedef logic [2:0] hex_idx_t;
   typedef logic [6:0] seg_t;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      ACK
   } arb_state_t;

   localparam seg_t HEX_OFF = 7'h7F;
   localparam int   NUM_HEX = 6;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from ptr+1 (mod N_REQ) upward
// and reports the first requester whose req bit is set.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   // walk the rotated priority order once; the first hit wins
   always_comb begin
      int cand;
      valid = 1'b0;
      idx   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = int'(ptr) + k;
         if (cand >= N_REQ) cand = cand - N_REQ;
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/hex_write_arbiter.sv
// Round-robin arbiter that serialises single-display writes from N_REQ
// clients into the six HEX display registers (active-low segments).
// Optional blinking is compiled in with the HEX_ARB_BLINK_EN macro.
module hex_write_arbiter
   import hex_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req,
   input  logic [3*N_REQ-1:0] req_addr,
   input  logic [7*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_blink,
   output logic [N_REQ-1:0]   ack,
   output logic               err,
   output logic               busy,
   output seg_t               HEX0,
   output seg_t               HEX1,
   output seg_t               HEX2,
   output seg_t               HEX3,
   output seg_t               HEX4,
   output seg_t               HEX5
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   arb_state_t       state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] gnt_idx;
   logic             pick_vld;
   logic [IDX_W-1:0] pick_idx;
   hex_idx_t         lat_addr;
   seg_t             lat_data;
   logic             lat_blink;
   seg_t             hex_reg [NUM_HEX];
   seg_t             hex_out [NUM_HEX];

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req   (req),
      .ptr   (ptr),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   // capture the winner's write while leaving IDLE; these are pure data
   // holding registers, so they carry no reset
   always_ff @(posedge CLOCK_50) begin
      if (state == IDLE && pick_vld) begin
         lat_addr  <= req_addr[int'(pick_idx)*3 +: 3];
         lat_data  <= req_data[int'(pick_idx)*7 +: 7];
         lat_blink <= req_blink[pick_idx];
      end
   end

   // control FSM: IDLE picks, GRANT commits the write, ACK pulses completion
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state   <= IDLE;
         ptr     <= IDX_W'(N_REQ - 1);
         gnt_idx <= '0;
         ack     <= '0;
         err     <= 1'b0;
         busy    <= 1'b0;
         for (int h = 0; h < NUM_HEX; h++) hex_reg[h] <= HEX_OFF;
      end else begin
         case (state)
            IDLE: begin
               ack <= '0;
               err <= 1'b0;
               if (pick_vld) begin
                  gnt_idx <= pick_idx;
                  busy    <= 1'b1;
                  state   <= GRANT;
               end
            end
            GRANT: begin
               // indices 6 and 7 address no display: flag instead of writing
               for (int h = 0; h < NUM_HEX; h++)
                  if (lat_addr == hex_idx_t'(h)) hex_reg[h] <= lat_data;
               err   <= (lat_addr >= hex_idx_t'(NUM_HEX));
               ack   <= {{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx;
               state <= ACK;
            end
            ACK: begin
               ack   <= '0;
               err   <= 1'b0;
               ptr   <= gnt_idx;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               ack   <= '0;
               err   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef HEX_ARB_BLINK_EN
   localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [NUM_HEX-1:0] blink_bits;
   logic [CNT_W-1:0]   blink_cnt;
   logic               blink_phase;

   // free-running half-period counter; phase flips on every wrap
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + 1'b1;
      end
   end

   // every valid write also refreshes that display's blink enable
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         blink_bits <= '0;
      end else if (state == GRANT) begin
         for (int h = 0; h < NUM_HEX; h++)
            if (lat_addr == hex_idx_t'(h)) blink_bits[h] <= lat_blink;
      end
   end

   // blinking displays go dark during the odd phase
   always_comb begin
      for (int h = 0; h < NUM_HEX; h++)
         hex_out[h] = (blink_bits[h] && blink_phase) ? HEX_OFF : hex_reg[h];
   end
`else
   logic unused_blink;
   assign unused_blink = lat_blink;

   // without blinking the displays show their registers directly
   always_comb begin
      for (int h = 0; h < NUM_HEX; h++) hex_out[h] = hex_reg[h];
   end
`endif

   assign HEX0 = hex_out[0];
   assign HEX1 = hex_out[1];
   assign HEX2 = hex_out[2];
   assign HEX3 = hex_out[3];
   assign HEX4 = hex_out[4];
   assign HEX5 = hex_out[5];

endmodule
